static_segment_register: RTL and testbench

- Single architectural register holding the CPU's static segment base value (SSR).
- Loaded from the internal data bus under a load strobe; drives its value continuously to segment/address-generation logic.
- Adds status outputs: sticky "loaded" flag and one-cycle update pulse, so the control unit can tell whether SSR was ever written and when it changes.

---
 rtl/static_segment_register.sv | 82 ++++++++
 tb/tb_static_segment_register.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/static_segment_register.sv
// Static segment base register (SSR) with sticky loaded flag and change pulse.
// Optional shadow/restore slot is enabled by defining SSR_SHADOW_EN.
module static_segment_register #(
  parameter int unsigned          WIDTH       = 16,
  parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_ssr,
  input  logic [WIDTH-1:0] ssr_data_in,
`ifdef SSR_SHADOW_EN
  input  logic             ssr_restore,
  output logic [WIDTH-1:0] ssr_prev_out,
`endif
  output logic [WIDTH-1:0] ssr_data_out,
  output logic             ssr_loaded,
  output logic             ssr_update
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             loaded_q;
  logic             loaded_d;
  logic             update_q;
  logic             update_d;

`ifdef SSR_SHADOW_EN
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;
`endif

  // The data compare is only evaluated under a load, so ssr_data_in may be X while idle.
  always_comb begin
    data_d   = data_q;
    loaded_d = loaded_q;
    update_d = 1'b0;
`ifdef SSR_SHADOW_EN
    shadow_d = shadow_q;
`endif
    if (load_ssr) begin
      data_d   = ssr_data_in;
      loaded_d = 1'b1;
      update_d = (ssr_data_in != data_q);
`ifdef SSR_SHADOW_EN
      shadow_d = data_q;
    end else if (ssr_restore) begin
      data_d   = shadow_q;
      shadow_d = data_q;
      update_d = (shadow_q != data_q);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      loaded_q <= 1'b0;
      update_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      loaded_q <= loaded_d;
      update_q <= update_d;
    end
  end

`ifdef SSR_SHADOW_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= RESET_VALUE;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign ssr_prev_out = shadow_q;
`endif

  assign ssr_data_out = data_q;
  assign ssr_loaded   = loaded_q;
  assign ssr_update   = update_q;

endmodule

// File: tb/tb_static_segment_register.sv
// Self-checking bench for static_segment_register: directed plan plus randomized
// loads/reset checked against a behavioural model of the register's rules.
module tb_static_segment_register;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_ssr = 1'b0;
  logic [W-1:0] ssr_data_in = '0;
  logic         restore = 1'b0;
  logic [W-1:0] ssr_data_out;
  logic         ssr_loaded;
  logic         ssr_update;
  logic [W-1:0] prev_out;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] exp_data;
  logic [W-1:0] exp_prev;
  logic         exp_loaded;
  logic         exp_update;

  always #5 clk = ~clk;

  static_segment_register #(.WIDTH(W), .RESET_VALUE(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_ssr     (load_ssr),
    .ssr_data_in  (ssr_data_in),
`ifdef SSR_SHADOW_EN
    .ssr_restore  (restore),
    .ssr_prev_out (prev_out),
`endif
    .ssr_data_out (ssr_data_out),
    .ssr_loaded   (ssr_loaded),
    .ssr_update   (ssr_update)
  );

`ifndef SSR_SHADOW_EN
  assign prev_out = '0;
`endif

  task automatic model_reset();
    exp_data   = 16'h0000;
    exp_prev   = 16'h0000;
    exp_loaded = 1'b0;
    exp_update = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, and return 1ns after it so outputs can be sampled.
  task automatic drive(input logic rst_v, input logic ld, input logic [W-1:0] d, input logic rs);
    logic [W-1:0] old;
    @(negedge clk);
    reset       = rst_v;
    load_ssr    = ld;
    ssr_data_in = d;
    restore     = rs;
    @(posedge clk);
    old = exp_data;
    if (rst_v) begin
      model_reset();
    end else if (ld) begin
      exp_data   = d;
      exp_prev   = old;
      exp_loaded = 1'b1;
      exp_update = (d != old);
`ifdef SSR_SHADOW_EN
    end else if (rs) begin
      exp_data   = exp_prev;
      exp_prev   = old;
      exp_update = (exp_data != old);
`endif
    end else begin
      exp_update = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (ssr_data_out !== 16'h0000 || ssr_loaded !== 1'b0 || ssr_update !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate: got data=%h loaded=%b update=%b, want 0000/0/0",
               ssr_data_out, ssr_loaded, ssr_update);
    end
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    checks++;
    if (ssr_data_out !== 16'h0000 || ssr_loaded !== 1'b0 || ssr_update !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got data=%h loaded=%b update=%b, want 0000/0/0",
               ssr_data_out, ssr_loaded, ssr_update);
    end
  endtask

  task automatic test_load_hold();
    int pulses;
    drive(1'b0, 1'b1, 16'h2000, 1'b0);
    checks++;
    if (ssr_data_out !== 16'h2000 || ssr_loaded !== 1'b1 || ssr_update !== 1'b1) begin
      errors++;
      $display("FAIL first_load: got data=%h loaded=%b update=%b, want 2000/1/1",
               ssr_data_out, ssr_loaded, ssr_update);
    end
    drive(1'b0, 1'b0, 16'h3500, 1'b0);
    checks++;
    if (ssr_data_out !== 16'h2000 || ssr_update !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_load: got data=%h update=%b, want 2000/0", ssr_data_out, ssr_update);
    end
    drive(1'b0, 1'b1, 16'h3500, 1'b0);
    pulses = (ssr_update === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 16'hxxxx, 1'b0);
      if (ssr_update === 1'b1) pulses++;
    end
    checks++;
    if (ssr_data_out !== 16'h3500 || pulses != 1) begin
      errors++;
      $display("FAIL load_then_idle: got data=%h pulses=%0d, want 3500/1", ssr_data_out, pulses);
    end
  endtask

  task automatic test_same_value();
    drive(1'b0, 1'b1, 16'h3500, 1'b0);
    checks++;
    if (ssr_data_out !== 16'h3500 || ssr_update !== 1'b0 || ssr_loaded !== 1'b1) begin
      errors++;
      $display("FAIL reload_same: got data=%h update=%b loaded=%b, want 3500/0/1",
               ssr_data_out, ssr_update, ssr_loaded);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 16'hA5A5, 1'b0);
    checks++;
    if (ssr_data_out !== 16'hA5A5 || ssr_update !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got data=%h update=%b, want a5a5/1", ssr_data_out, ssr_update);
    end
    drive(1'b0, 1'b1, 16'h5A5A, 1'b0);
    checks++;
    if (ssr_data_out !== 16'h5A5A || ssr_update !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got data=%h update=%b, want 5a5a/1", ssr_data_out, ssr_update);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    checks++;
    if (ssr_data_out !== 16'h5A5A || ssr_update !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got data=%h update=%b, want 5a5a/0", ssr_data_out, ssr_update);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    load_ssr = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (ssr_data_out !== 16'h0000 || ssr_loaded !== 1'b0 || ssr_update !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got data=%h loaded=%b update=%b, want 0000/0/0",
               ssr_data_out, ssr_loaded, ssr_update);
    end
    drive(1'b1, 1'b1, 16'hBEEF, 1'b0);
    checks++;
    if (ssr_data_out !== 16'h0000 || ssr_loaded !== 1'b0 || ssr_update !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_load: got data=%h loaded=%b update=%b, want 0000/0/0",
               ssr_data_out, ssr_loaded, ssr_update);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_random();
    logic         ld, rs, rv;
    logic [W-1:0] d;
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 39) == 0);
      ld = $urandom_range(0, 1);
      rs = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       d = exp_data;
        1:       d = exp_prev;
        default: d = W'($urandom);
      endcase
      drive(rv, ld, d, rs);
      checks++;
      if (ssr_data_out !== exp_data || ssr_loaded !== exp_loaded || ssr_update !== exp_update) begin
        errors++;
        $display("FAIL random[%0d]: got data=%h loaded=%b update=%b, want %h/%b/%b",
                 i, ssr_data_out, ssr_loaded, ssr_update, exp_data, exp_loaded, exp_update);
      end
`ifdef SSR_SHADOW_EN
      checks++;
      if (prev_out !== exp_prev) begin
        errors++;
        $display("FAIL random_shadow[%0d]: got %h, want %h", i, prev_out, exp_prev);
      end
`endif
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

`ifdef SSR_SHADOW_EN
  task automatic test_shadow();
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    checks++;
    if (prev_out !== 16'h0000) begin
      errors++;
      $display("FAIL shadow_reset: got %h, want 0000", prev_out);
    end
    drive(1'b0, 1'b1, 16'h1111, 1'b0);
    drive(1'b0, 1'b1, 16'h2222, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    checks++;
    if (ssr_data_out !== 16'h1111 || prev_out !== 16'h2222 || ssr_update !== 1'b1) begin
      errors++;
      $display("FAIL shadow_restore: got data=%h prev=%h update=%b, want 1111/2222/1",
               ssr_data_out, prev_out, ssr_update);
    end
    drive(1'b0, 1'b1, 16'h3333, 1'b1);
    checks++;
    if (ssr_data_out !== 16'h3333 || prev_out !== 16'h1111) begin
      errors++;
      $display("FAIL shadow_load_priority: got data=%h prev=%h, want 3333/1111",
               ssr_data_out, prev_out);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_load_hold();
    test_same_value();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef SSR_SHADOW_EN
    test_shadow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, limit 200000");
    $fatal(1);
  end

endmodule
